byte_lane_sram: RTL and testbench

- Single-port, byte-addressed, 64 KiB synchronous memory with 4 byte-lane write enables.
- Used twice at SoC level: once as instruction memory and once as data memory for the pipelined RV32I core.
- Stores 32-bit words little-endian across 4 consecutive byte locations.
- Exposes its byte array as `mem` so benches can preload it with $readmemh and read or poke it hierarchically.

---
 rtl/byte_lane_sram.sv | 115 +++++++++++
 tb/tb_byte_lane_sram.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/byte_lane_sram.sv
// rtl/byte_lane_sram.sv - single-port byte-addressed SRAM with per-lane write enables
//
// Purpose:
//   64 KiB byte-addressed synchronous memory. Each access covers four
//   consecutive bytes that are stored little-endian. Lane i targets
//   mem[(address + i) mod 2**ADDR_WIDTH], so unaligned and wrapping
//   accesses are legal. Reads are registered and return the contents from
//   before the write (read-first). The byte array is named `mem` so that
//   benches can preload it or inspect it hierarchically.
//
// Optional feature (macro SRAM_HALT_FLAG_EN):
//   Adds a sticky `halt` output. It is set when any enabled lane writes the
//   byte 8'hFF to HALT_ADDR, and it is cleared only by reset.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-low reset (clears read_data/halt)
//   w_en       in   4   per-lane write enable, bit i -> byte i
//   address    in   16  byte address of the word access
//   write_data in   32  write word, byte i = write_data[8i+7:8i]
//   read_data  out  32  registered read word
//   halt       out  1   sticky halt flag (SRAM_HALT_FLAG_EN only)

module byte_lane_sram #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] HALT_ADDR  = 16'hFFFC
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              w_en,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   write_data,
`ifdef SRAM_HALT_FLAG_EN
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    halt
`else
   output logic [DATA_WIDTH-1:0]   read_data
`endif
);

   localparam int LANES = 4;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Byte storage. It has no reset and no initial contents.
   logic [7:0] mem [0:DEPTH-1];

   // Per-lane byte addresses. The add is truncated to ADDR_WIDTH, so an
   // access that runs past the top of the array wraps to address 0.
   logic [ADDR_WIDTH-1:0] lane_addr [LANES];

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lane_addr[i] = address + ADDR_WIDTH'(i);
      end
   end

   // Write port. This block has no reset term, so it cannot clear `mem`.
   // Writes are gated by rst, which drops any write that coincides with an
   // asserted reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) begin
            if (w_en[i]) begin
               mem[lane_addr[i]] <= write_data[8*i +: 8];
            end
         end
      end
   end

   // Read port. Every cycle is an access. The old array contents are sampled
   // with a nonblocking assignment on the same edge as the write, which gives
   // read-first behaviour for overlapping bytes.
   logic [DATA_WIDTH-1:0] read_word;

   always_comb begin
      read_word = '0;
      for (int i = 0; i < LANES; i++) begin
         read_word[8*i +: 8] = mem[lane_addr[i]];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_data <= '0;
      end else begin
         read_data <= read_word;
      end
   end

`ifdef SRAM_HALT_FLAG_EN
   // Any lane may be the one that lands on HALT_ADDR. This includes
   // unaligned stores.
   logic halt_hit;

   always_comb begin
      halt_hit = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (w_en[i] && (lane_addr[i] == HALT_ADDR) &&
             (write_data[8*i +: 8] == 8'hFF)) begin
            halt_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halt <= 1'b0;
      end else if (halt_hit) begin
         halt <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_byte_lane_sram.sv
// tb/tb_byte_lane_sram.sv - directed self-checking bench for byte_lane_sram
//
// Purpose:
//   Drives directed vectors with hand-computed expected values. It covers
//   asynchronous reset, write suppression during reset, full-word and
//   single-lane writes, read-first ordering, address wrap-around and, with
//   SRAM_HALT_FLAG_EN, the sticky halt flag.

module tb_byte_lane_sram;

   logic        clk;
   logic        rst;
   logic [3:0]  w_en;
   logic [15:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
`ifdef SRAM_HALT_FLAG_EN
   logic        halt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   byte_lane_sram dut (
      .clk        (clk),
      .rst        (rst),
      .w_en       (w_en),
      .address    (address),
      .write_data (write_data),
`ifdef SRAM_HALT_FLAG_EN
      .read_data  (read_data),
      .halt       (halt)
`else
      .read_data  (read_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One access. Inputs are applied, one rising edge passes, and outputs are
   // then sampled 1 ns after that edge.
   task automatic access(input logic [3:0] we, input logic [15:0] a,
                         input logic [31:0] d);
      w_en       = we;
      address    = a;
      write_data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      w_en       = 4'h0;
      address    = 16'h0000;
      write_data = 32'h0;
      @(posedge clk);
      #1;

      // Preload word 0 through the port, then read it back so that
      // read_data holds a stale nonzero value before reset.
      access(4'hF, 16'h0000, 32'h11223344);
      access(4'h0, 16'h0000, 32'h0);
      check_eq("preload_rd", read_data, 32'h11223344);

      // The asynchronous reset clears read_data before any clock edge.
      rst = 1'b0;
      #1;
      check_eq("rst_async", read_data, 32'h0);

      // While reset is held, read_data stays 0 and writes are dropped.
      access(4'hF, 16'h0000, 32'hCAFEBABE);
      check_eq("rst_hold", read_data, 32'h0);
      w_en = 4'h0;
      rst  = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_release", read_data, 32'h11223344);
`ifdef SRAM_HALT_FLAG_EN
      check_eq("halt_reset", {31'b0, halt}, 32'h0);
`endif

      // Full-word write, followed by a write with w_en=0 that must not land.
      access(4'hF, 16'h9000, 32'hDEADBEEF);
      access(4'h0, 16'h9000, 32'hFFFFFFFF);
      check_eq("full_word_rd", read_data, 32'hDEADBEEF);
      access(4'h0, 16'h9000, 32'h0);
      check_eq("no_write_rd", read_data, 32'hDEADBEEF);
      check_eq("mem_9000", {24'h0, dut.mem[16'h9000]}, 32'h000000EF);
      check_eq("mem_9003", {24'h0, dut.mem[16'h9003]}, 32'h000000DE);

      // Single-lane write to lane 2 only.
      access(4'hF, 16'h9078, 32'h00000000);
      access(4'b0100, 16'h9078, 32'hAABBCCDD);
      access(4'h0, 16'h9078, 32'h0);
      check_eq("lane2_rd", read_data, 32'h00BB0000);

      // Read-first: the edge that performs the write returns the old data.
      access(4'hF, 16'h9080, 32'h00000000);
      access(4'hF, 16'h9080, 32'h12345678);
      check_eq("rd_first_old", read_data, 32'h00000000);
      access(4'h0, 16'h9080, 32'h0);
      check_eq("rd_first_new", read_data, 32'h12345678);

      // A word write at 0xFFFE wraps its upper two bytes to 0x0000/0x0001.
      access(4'hF, 16'hFFFE, 32'h44332211);
      check_eq("wrap_fffe", {24'h0, dut.mem[16'hFFFE]}, 32'h00000011);
      check_eq("wrap_ffff", {24'h0, dut.mem[16'hFFFF]}, 32'h00000022);
      check_eq("wrap_0000", {24'h0, dut.mem[16'h0000]}, 32'h00000033);
      check_eq("wrap_0001", {24'h0, dut.mem[16'h0001]}, 32'h00000044);
      access(4'h0, 16'hFFFE, 32'h0);
      check_eq("wrap_rd", read_data, 32'h44332211);
      // Word 0 is now {11,22,44,33}: bytes 2-3 are still from the preload.
      access(4'h0, 16'h0000, 32'h0);
      check_eq("wrap_low_rd", read_data, 32'h11224433);

`ifdef SRAM_HALT_FLAG_EN
      // 0xFE at HALT_ADDR does not trigger the flag.
      access(4'h1, 16'hFFFC, 32'h000000FE);
      check_eq("halt_fe", {31'b0, halt}, 32'h0);
      // 0xFF written on lane 0 at a different address does not trigger it.
      access(4'h1, 16'hFFF8, 32'h000000FF);
      check_eq("halt_wrong_addr", {31'b0, halt}, 32'h0);
      access(4'h1, 16'hFFFC, 32'h000000FF);
      check_eq("halt_set", {31'b0, halt}, 32'h1);
      access(4'hF, 16'h9000, 32'h00000000);
      check_eq("halt_sticky", {31'b0, halt}, 32'h1);
      rst = 1'b0;
      #1;
      check_eq("halt_rst", {31'b0, halt}, 32'h0);
      w_en = 4'h0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      // An unaligned store whose lane 1 lands 0xFF on HALT_ADDR.
      access(4'b0010, 16'hFFFB, 32'h0000FF00);
      check_eq("halt_lane1", {31'b0, halt}, 32'h1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
